// File: rtl/studio_keypad_pkg.sv
// Shared constants, index types and the PS/2 set-2 scancode map for the
// Studio II keypad controller.
package studio_keypad_pkg;

   localparam int MAX_PADS = 4;
   localparam int MAX_KEYS = 16;

   typedef logic [3:0] key_idx_t;
   typedef logic [1:0] pad_idx_t;

   typedef struct packed {
      logic     valid;
      pad_idx_t pad;
      key_idx_t key;
   } map_entry_t;

   function automatic map_entry_t map_hit(input pad_idx_t pad, input key_idx_t key);
      map_entry_t e;
      e.valid = 1'b1;
      e.pad   = pad;
      e.key   = key;
      return e;
   endfunction

   // Key index equals the keypad legend digit, so key 0 is the last key of each row.
   function automatic map_entry_t scan_lookup(input logic [7:0] code);
      map_entry_t e;
      e = '0;
      case (code)
         8'h16: e = map_hit(2'd0, 4'd1);
         8'h1E: e = map_hit(2'd0, 4'd2);
         8'h26: e = map_hit(2'd0, 4'd3);
         8'h25: e = map_hit(2'd0, 4'd4);
         8'h2E: e = map_hit(2'd0, 4'd5);
         8'h36: e = map_hit(2'd0, 4'd6);
         8'h3D: e = map_hit(2'd0, 4'd7);
         8'h3E: e = map_hit(2'd0, 4'd8);
         8'h46: e = map_hit(2'd0, 4'd9);
         8'h45: e = map_hit(2'd0, 4'd0);
         8'h15: e = map_hit(2'd1, 4'd1);
         8'h1D: e = map_hit(2'd1, 4'd2);
         8'h24: e = map_hit(2'd1, 4'd3);
         8'h2D: e = map_hit(2'd1, 4'd4);
         8'h2C: e = map_hit(2'd1, 4'd5);
         8'h35: e = map_hit(2'd1, 4'd6);
         8'h3C: e = map_hit(2'd1, 4'd7);
         8'h43: e = map_hit(2'd1, 4'd8);
         8'h44: e = map_hit(2'd1, 4'd9);
         8'h4D: e = map_hit(2'd1, 4'd0);
         8'h1C: e = map_hit(2'd2, 4'd1);
         8'h1B: e = map_hit(2'd2, 4'd2);
         8'h23: e = map_hit(2'd2, 4'd3);
         8'h2B: e = map_hit(2'd2, 4'd4);
         8'h34: e = map_hit(2'd2, 4'd5);
         8'h33: e = map_hit(2'd2, 4'd6);
         8'h3B: e = map_hit(2'd2, 4'd7);
         8'h42: e = map_hit(2'd2, 4'd8);
         8'h4B: e = map_hit(2'd2, 4'd9);
         8'h4C: e = map_hit(2'd2, 4'd0);
         8'h1A: e = map_hit(2'd3, 4'd1);
         8'h22: e = map_hit(2'd3, 4'd2);
         8'h21: e = map_hit(2'd3, 4'd3);
         8'h2A: e = map_hit(2'd3, 4'd4);
         8'h32: e = map_hit(2'd3, 4'd5);
         8'h31: e = map_hit(2'd3, 4'd6);
         8'h3A: e = map_hit(2'd3, 4'd7);
         8'h41: e = map_hit(2'd3, 4'd8);
         8'h49: e = map_hit(2'd3, 4'd9);
         8'h4A: e = map_hit(2'd3, 4'd0);
         default: e = '0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/studio_keypad_map.sv
// Combinational scancode decode: {extended, scancode} -> {valid, pad, key}.
// Extended codes never map to a keypad key.
module studio_keypad_map
   import studio_keypad_pkg::*;
(
   input  logic       extended,
   input  logic [7:0] scancode,
   output logic       valid,
   output pad_idx_t   pad,
   output key_idx_t   key
);

   map_entry_t entry;

   // Table lookup, masked by the extended prefix.
   always_comb begin
      entry = scan_lookup(scancode);
      valid = entry.valid & ~extended;
      pad   = entry.pad;
      key   = entry.key;
   end

endmodule

// File: rtl/studio_keypad_ctrl.sv
// Studio II keypad controller: per-key pressed bitmap for NUM_PADS keypads,
// CPU-written key-select latch, and one active-low EF flag per pad.
// Optional build macro KEYPAD_HOLD_EN adds a per-pad minimum-assert timer
// that defers releases until the pad's hold down-counter reaches zero.
module studio_keypad_ctrl
   import studio_keypad_pkg::*;
#(
   parameter int          NUM_PADS     = 2,
   parameter int          KEYS_PER_PAD = 10,
   parameter int          SEL_PORT     = 2,
   parameter logic [15:0] HOLD_CYCLES  = 16'd50000
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [10:0]         ps2_key,
   input  logic                io_out,
   input  logic [2:0]          io_n,
   input  logic [7:0]          io_dout,
   output logic [NUM_PADS-1:0] ef_n,
   output logic [3:0]          key_sel,
   output logic [NUM_PADS-1:0] any_key
);

   localparam logic [2:0] SEL_N = 3'(SEL_PORT);
   localparam logic [2:0] PADS_W = 3'(NUM_PADS);
   localparam logic [4:0] KEYS_W = 5'(KEYS_PER_PAD);

   // A zero hold time is rejected; leave the macro undefined to get immediate releases.
   if (NUM_PADS < 1 || NUM_PADS > MAX_PADS || KEYS_PER_PAD < 1 || KEYS_PER_PAD > MAX_KEYS ||
       SEL_PORT < 0 || SEL_PORT > 7 || HOLD_CYCLES == 16'd0) begin : g_bad_param
      $error("studio_keypad_ctrl: illegal parameter combination");
   end

   logic     old_toggle;
   logic     ps2_event;
   logic     map_valid;
   pad_idx_t map_pad;
   key_idx_t map_key;
   logic     key_hit;
   logic     unused_dout;

   logic [NUM_PADS-1:0][KEYS_PER_PAD-1:0] bitmap;
   logic [NUM_PADS-1:0][KEYS_PER_PAD-1:0] set_hit;
   logic [NUM_PADS-1:0][KEYS_PER_PAD-1:0] clr_hit;
   logic [NUM_PADS-1:0]                   sel_hit;

   assign unused_dout = ^io_dout[7:4];
   assign ps2_event   = ps2_key[10] ^ old_toggle;

   studio_keypad_map u_map (
      .extended (ps2_key[8]),
      .scancode (ps2_key[7:0]),
      .valid    (map_valid),
      .pad      (map_pad),
      .key      (map_key)
   );

   assign key_hit = ps2_event && map_valid &&
                    ({1'b0, map_pad} < PADS_W) && ({1'b0, map_key} < KEYS_W);

   // Expand the decoded event into one-hot set/clear strobes over the bitmap.
   always_comb begin
      set_hit = '0;
      clr_hit = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         for (int k = 0; k < KEYS_PER_PAD; k++) begin
            if (key_hit && map_pad == pad_idx_t'(p) && map_key == key_idx_t'(k)) begin
               set_hit[p][k] = ps2_key[9];
               clr_hit[p][k] = ~ps2_key[9];
            end
         end
      end
   end

   // Toggle tracker follows the input during reset so leaving reset is silent.
   always_ff @(posedge clk_sys) begin
      old_toggle <= ps2_key[10];
   end

   // Key-select latch written by OUT on the select port only.
   always_ff @(posedge clk_sys) begin
      if (reset)
         key_sel <= '0;
      else if (io_out && io_n == SEL_N)
         key_sel <= io_dout[3:0];
   end

`ifdef KEYPAD_HOLD_EN
   logic [NUM_PADS-1:0][15:0]             hold_cnt;
   logic [NUM_PADS-1:0][KEYS_PER_PAD-1:0] pend;

   // Press reloads the pad timer; releases wait in pend until the timer is zero.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bitmap   <= '0;
         pend     <= '0;
         hold_cnt <= '0;
      end else begin
         for (int p = 0; p < NUM_PADS; p++) begin
            if (|set_hit[p])
               hold_cnt[p] <= HOLD_CYCLES;
            else if (hold_cnt[p] != 16'd0)
               hold_cnt[p] <= hold_cnt[p] - 16'd1;

            if (hold_cnt[p] == 16'd0) begin
               bitmap[p] <= (bitmap[p] | set_hit[p]) & ~((clr_hit[p] | pend[p]) & ~set_hit[p]);
               pend[p]   <= '0;
            end else begin
               bitmap[p] <= bitmap[p] | set_hit[p];
               pend[p]   <= (pend[p] | clr_hit[p]) & ~set_hit[p];
            end
         end
      end
   end
`else
   // Presses set and releases clear their own bit immediately.
   always_ff @(posedge clk_sys) begin
      if (reset)
         bitmap <= '0;
      else
         bitmap <= (bitmap | set_hit) & ~clr_hit;
   end
`endif

   // Selected-key lookup per pad; a select beyond the pad width matches nothing.
   always_comb begin
      sel_hit = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         for (int k = 0; k < KEYS_PER_PAD; k++) begin
            if (key_sel == key_idx_t'(k) && bitmap[p][k])
               sel_hit[p] = 1'b1;
         end
      end
   end

   // Registered EF flags and per-pad activity status.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ef_n    <= '1;
         any_key <= '0;
      end else begin
         ef_n <= ~sel_hit;
         for (int p = 0; p < NUM_PADS; p++)
            any_key[p] <= |bitmap[p];
      end
   end

endmodule

// File: tb/tb_studio_keypad_ctrl.sv
// Directed bench for studio_keypad_ctrl (NUM_PADS=2, KEYS_PER_PAD=10).
// Define KEYPAD_HOLD_EN for both files to also exercise the hold timer.
module tb_studio_keypad_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic        io_out;
   logic [2:0]  io_n;
   logic [7:0]  io_dout;
   logic [1:0]  ef_n;
   logic [3:0]  key_sel;
   logic [1:0]  any_key;

   logic tgl;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk_sys = ~clk_sys;

   studio_keypad_ctrl #(
      .NUM_PADS     (2),
      .KEYS_PER_PAD (10),
      .SEL_PORT     (2),
      .HOLD_CYCLES  (16'd100)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ps2_key (ps2_key),
      .io_out  (io_out),
      .io_n    (io_n),
      .io_dout (io_dout),
      .ef_n    (ef_n),
      .key_sel (key_sel),
      .any_key (any_key)
   );

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drive one PS/2 event and wait for it to reach ef_n.
   task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
      tgl = ~tgl;
      ps2_key = {tgl, pressed, ext, code};
      tick();
      tick();
   endtask

   // One-cycle OUT strobe, then wait for ef_n to follow.
   task automatic cpu_out(input logic [2:0] n, input logic [7:0] d);
      io_out  = 1'b1;
      io_n    = n;
      io_dout = d;
      tick();
      io_out = 1'b0;
      tick();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tgl     = 1'b1;
      reset   = 1'b1;
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h2E};
      io_out  = 1'b0;
      io_n    = 3'd0;
      io_dout = 8'h00;
      ticks(3);
      chk("rst_ef_n", ef_n, 8'h03);
      chk("rst_any_key", any_key, 8'h00);
      chk("rst_key_sel", key_sel, 8'h00);
      reset = 1'b0;
      ticks(3);
      chk("rst_release_quiet", any_key, 8'h00);

      // basic press / release of pad 0 key 5
      cpu_out(3'd2, 8'h05);
      chk("sel5", key_sel, 8'h05);
      send(1'b1, 1'b0, 8'h2E);
      chk("press5_ef", ef_n, 8'h02);
      chk("press5_any", any_key, 8'h01);
      send(1'b0, 1'b0, 8'h2E);
      chk("rel5_ef", ef_n, 8'h03);
      chk("rel5_any", any_key, 8'h00);

      // repeated make, then break of a key not held
      send(1'b1, 1'b0, 8'h2E);
      send(1'b1, 1'b0, 8'h2E);
      chk("repeat_make", any_key, 8'h01);
      send(1'b0, 1'b0, 8'h2E);
      chk("repeat_rel", any_key, 8'h00);
      send(1'b0, 1'b0, 8'h16);
      chk("break_unheld_any", any_key, 8'h00);
      chk("break_unheld_ef", ef_n, 8'h03);

      // two keys on pad 0, release only clears its own bit
      send(1'b1, 1'b0, 8'h26);
      send(1'b1, 1'b0, 8'h2E);
      cpu_out(3'd2, 8'h03);
      chk("multi_sel3", ef_n, 8'h02);
      send(1'b0, 1'b0, 8'h2E);
      chk("multi_rel5_ef", ef_n, 8'h02);
      chk("multi_rel5_any", any_key, 8'h01);
      cpu_out(3'd2, 8'h05);
      chk("multi_sel5", ef_n, 8'h03);
      send(1'b0, 1'b0, 8'h26);
      chk("multi_rel3", any_key, 8'h00);

      // pad independence
      send(1'b1, 1'b0, 8'h2C);
      chk("pad1_ef", ef_n, 8'h01);
      chk("pad1_any", any_key, 8'h02);
      send(1'b0, 1'b0, 8'h2C);

      // PS/2 event and OUT strobe in the same cycle
      tgl     = ~tgl;
      ps2_key = {tgl, 1'b1, 1'b0, 8'h1E};
      io_out  = 1'b1;
      io_n    = 3'd2;
      io_dout = 8'h02;
      tick();
      io_out = 1'b0;
      tick();
      chk("simul_ef", ef_n, 8'h02);
      chk("simul_sel", key_sel, 8'h02);

      // out-of-range select and foreign port
      send(1'b1, 1'b0, 8'h1D);
      chk("both_key2_ef", ef_n, 8'h00);
      chk("both_key2_any", any_key, 8'h03);
      cpu_out(3'd2, 8'h0C);
      chk("sel12_ef", ef_n, 8'h03);
      chk("sel12_val", key_sel, 8'h0C);
      cpu_out(3'd1, 8'h05);
      chk("port1_ignored", key_sel, 8'h0C);
      cpu_out(3'd2, 8'h02);
      chk("sel2_again", ef_n, 8'h00);
      send(1'b0, 1'b0, 8'h1E);
      send(1'b0, 1'b0, 8'h1D);
      chk("both_rel", any_key, 8'h00);

      // ignored events
      send(1'b1, 1'b1, 8'h16);
      chk("extended_ign", any_key, 8'h00);
      send(1'b1, 1'b0, 8'h5A);
      chk("unmapped_ign", any_key, 8'h00);
      send(1'b1, 1'b0, 8'h1B);
      chk("pad2_ign_any", any_key, 8'h00);
      chk("pad2_ign_ef", ef_n, 8'h03);

      // key 0 is the last code of each row
      cpu_out(3'd2, 8'h00);
      send(1'b1, 1'b0, 8'h45);
      chk("key0_pad0", ef_n, 8'h02);
      send(1'b1, 1'b0, 8'h4D);
      chk("key0_pad1", ef_n, 8'h00);
      send(1'b0, 1'b0, 8'h45);
      send(1'b0, 1'b0, 8'h4D);
      chk("key0_rel", ef_n, 8'h03);

      // reset with a key held
      cpu_out(3'd2, 8'h01);
      send(1'b1, 1'b0, 8'h16);
      chk("pre_reset_ef", ef_n, 8'h02);
      reset = 1'b1;
      tick();
      chk("mid_reset_ef", ef_n, 8'h03);
      chk("mid_reset_sel", key_sel, 8'h00);
      chk("mid_reset_any", any_key, 8'h00);
      reset = 1'b0;
      tick();

`ifdef KEYPAD_HOLD_EN
      // release pended until the pad timer expires (~100 cycles after the press)
      cpu_out(3'd2, 8'h01);
      send(1'b1, 1'b0, 8'h15);
      chk("hold_press", ef_n, 8'h01);
      ticks(8);
      send(1'b0, 1'b0, 8'h15);
      chk("hold_early_rel", ef_n, 8'h01);
      ticks(79);
      chk("hold_c90", ef_n, 8'h01);
      ticks(20);
      chk("hold_c110_ef", ef_n, 8'h03);
      chk("hold_c110_any", any_key, 8'h00);

      // re-press cancels the pending release
      send(1'b1, 1'b0, 8'h15);
      send(1'b0, 1'b0, 8'h15);
      send(1'b1, 1'b0, 8'h15);
      ticks(150);
      chk("hold_cancel", ef_n, 8'h01);
      send(1'b0, 1'b0, 8'h15);
      chk("hold_expired_rel", ef_n, 8'h03);

      // reset clears a pending release and the held bit
      cpu_out(3'd2, 8'h01);
      send(1'b1, 1'b0, 8'h15);
      send(1'b0, 1'b0, 8'h15);
      ticks(5);
      chk("hold_pre_reset", ef_n, 8'h01);
      reset = 1'b1;
      tick();
      chk("hold_reset_ef", ef_n, 8'h03);
      reset = 1'b0;
      ticks(120);
      chk("hold_reset_any", any_key, 8'h00);
`else
      // without the hold timer a release is seen right away
      cpu_out(3'd2, 8'h01);
      send(1'b1, 1'b0, 8'h15);
      chk("nohold_press", ef_n, 8'h01);
      send(1'b0, 1'b0, 8'h15);
      chk("nohold_rel", ef_n, 8'h03);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/studio_keypad_ctrl.md
Name: studio_keypad_ctrl

Overview:
Parametrised keypad controller for the Studio II core. It replaces the single "last key" register with a full per-key pressed bitmap covering NUM_PADS keypads, including proper release tracking. A CPU-writable key-select latch is set through an OUT instruction, and one active-low EF line per pad reports whether the selected key is held on that pad. It sits between the PS/2 key stream and the cdp1802 EF inputs.

Parameters:
NUM_PADS, 2, number of keypads, legal 1..4; pads 2..3 use map slots that are present in the package.
KEYS_PER_PAD, 10, keys per pad, legal 1..16; key index = keypad legend digit.
SEL_PORT, 2, io_n value whose OUT strobe loads key_sel.
HOLD_CYCLES, 16'd50000, minimum assert time in clk_sys cycles; used only with KEYPAD_HOLD_EN.

Ports:
clk_sys  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scancode.
io_out  in  1  one-cycle CPU OUT strobe.
io_n  in  3  CPU N lines.
io_dout  in  8  CPU OUT data.
ef_n  out  NUM_PADS  active-low flag per pad: 0 = selected key held on pad p.
key_sel  out  4  current key-select latch.
any_key  out  NUM_PADS  1 = at least one key held on pad p (status/debug).

Behaviour:
- One clock, clk_sys. Reset is synchronous and active-high.
- Reset values: all bitmap bits 0; key_sel = 0; ef_n = all 1; any_key = 0.
- During reset, old_toggle <= ps2_key[10], so releasing reset never produces a spurious event.
- Event detect: an event occurs when ps2_key[10] != old_toggle. old_toggle updates every cycle.
- Decode: {extended, scancode} goes to the key_map sub-module, which returns valid, pad and key combinationally.
  - If extended = 1, the event is ignored.
  - If the code is unmapped, the event is ignored.
  - If pad >= NUM_PADS or key >= KEYS_PER_PAD, the event is ignored.
- Bitmap update, at the event edge:
  - pressed = 1 sets bit [pad][key]; pressed = 0 clears it.
  - A repeated make code for a held key causes no change.
  - A break for a key that is not held causes no change.
- Select latch: on io_out = 1 with io_n == SEL_PORT, key_sel <= io_dout[3:0]. Other ports are ignored.
- Output: ef_n[p] <= ~bitmap[p][key_sel], registered.
  - If key_sel >= KEYS_PER_PAD, ef_n[p] = 1.
  - any_key[p] <= OR of bitmap[p], registered.
- Latency:
  - PS/2 event to ef_n change: 2 cycles (bitmap register, then output register).
  - OUT strobe to ef_n change: 2 cycles.
- Simultaneous PS/2 event and OUT strobe in the same cycle: both updates apply. ef_n then reflects the new key_sel and the new bitmap together.
- Multiple keys held on one pad: each bit is independent, with no ghosting. A release clears only its own bit.
- Pads are independent. A key on pad 0 never affects ef_n[1].

Optional Feature:
Macro KEYPAD_HOLD_EN.
- Defined: each pad has a 16-bit hold counter.
  - A press on pad p loads HOLD_CYCLES.
  - The counter decrements to 0, one per cycle.
  - A release clears the bitmap bit only once the pad's counter is 0. Otherwise the release is pended, one pending bit per key, and applied when the counter reaches 0.
  - A new press of the same key cancels its pending release.
  - Reset clears all counters and pending bits.
- Undefined: no counters and no pending bits; releases apply immediately.

Decomposition:
- Package studio_keypad_pkg holds:
  - constants MAX_PADS = 4 and MAX_KEYS = 16;
  - typedef key_idx_t (4 bits) and pad_idx_t (2 bits);
  - the scancode map table.
- Scancode map:
  - pad 0 keys 1..9,0 = 16,1E,26,25,2E,36,3D,3E,46,45;
  - pad 1 keys 1..9,0 = 15,1D,24,2D,2C,35,3C,43,44,4D;
  - pad 2 keys 1..9,0 = 1C,1B,23,2B,34,33,3B,42,4B,4C;
  - pad 3 keys 1..9,0 = 1A,22,21,2A,32,31,3A,41,49,4A.
- Sub-module studio_keypad_map: combinational lookup from scancode to {valid, pad, key}.

Test Plan:
1. Reset, then OUT port 2 data 8'h05, then toggle ps2_key = {1,1,0,8'h2E} -> ef_n = 2'b10 two cycles after the event; any_key = 2'b01.
2. Same key held, then toggle ps2_key = {1,0,0,8'h2E} (break) -> ef_n = 2'b11 after 2 cycles; any_key = 0.
3. Keys 3 and 5 held on pad 0, OUT key_sel 3, then release key 5 -> ef_n[0] stays 0; OUT key_sel 5 -> ef_n[0] = 1.
4. OUT data 8'h0C (key 12 >= KEYS_PER_PAD) with key 2 held on every pad -> ef_n = all 1s. OUT on io_n = 1 with data 5 -> key_sel unchanged.
5. Extended event {1,1,1,8'h16}, unmapped code 8'h5A, and a pad-2 code with NUM_PADS = 2 -> bitmap unchanged; ef_n = all 1s.
6. (KEYPAD_HOLD_EN, HOLD_CYCLES = 100) Press pad 1 key 1, OUT key_sel 1, release after 10 cycles -> ef_n[1] = 0 until cycle 100 after the press, then 1. Assert reset mid-hold -> ef_n = all 1s on the next cycle.
